// File: rtl/mesh_pkg.sv
// Shared mesh types: address widths, packet payload and address pack/unpack helpers.
package mesh_pkg;

    localparam int unsigned MESH_X_NODES = 4;
    localparam int unsigned MESH_Y_NODES = 4;
    localparam int unsigned XW           = $clog2(MESH_X_NODES);
    localparam int unsigned YW           = $clog2(MESH_Y_NODES);
    localparam int unsigned AW           = XW + YW;
    localparam int unsigned TS_W         = 16;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STAT_W       = 16;

    typedef logic [AW-1:0] addr_t;

    typedef struct packed {
        addr_t             dest;
        addr_t             source;
        logic [TS_W-1:0]   timestamp;
        logic [DATA_W-1:0] data;
    } packet_t;

    // Node address layout: Y in the upper field, X in the lower field.
    function automatic addr_t pack_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {y, x};
    endfunction

    function automatic logic [XW-1:0] addr_x(input addr_t a);
        return a[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] addr_y(input addr_t a);
        return a[AW-1:XW];
    endfunction

endpackage

// File: rtl/mesh_ni_fifo.sv
// Parameterised-depth packet FIFO with full/empty/occupancy; DEPTH must be a power of two >= 2.
module mesh_ni_fifo
    import mesh_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  packet_t                      wr_data_i,
    input  logic                         rd_en_i,
    output packet_t                      rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    packet_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A full FIFO refuses writes even when a read happens in the same cycle.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_wr && !do_rd) count_d = count_q + CNT_W'(1);
        if (!do_wr && do_rd) count_d = count_q - CNT_W'(1);
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/mesh_network_interface.sv
// Core-side mesh endpoint: injection FIFO toward the router, 2-entry ejection buffer
// toward the sink, traffic counters and sticky error flags.
// Optional feature macro MESH_NI_LATENCY_EN: timestamps injected packets and reports
// per-packet latency on ejection.
module mesh_network_interface
    import mesh_pkg::*;
#(
    parameter int unsigned X_NODES  = 4,
    parameter int unsigned Y_NODES  = 4,
    parameter int unsigned X_LOC    = 0,
    parameter int unsigned Y_LOC    = 0,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  packet_t             i_tx_data,
    input  logic                i_tx_val,
    output logic                o_tx_ready,
    output packet_t             o_data,
    output logic                o_data_val,
    input  logic                i_en,
    input  packet_t             i_data,
    input  logic                i_data_val,
    output logic                o_en,
    output packet_t             o_rx_data,
    output logic                o_rx_val,
    input  logic                i_rx_ready,
    output logic [STAT_W-1:0]   o_tx_count,
    output logic [STAT_W-1:0]   o_rx_count,
    output logic                o_dest_err,
    output logic                o_overflow,
    output logic [TS_WIDTH-1:0] o_latency,
    output logic                o_latency_val
);

    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH + 1);
    localparam int unsigned RX_DEPTH = 2;
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH + 1);
    localparam addr_t       LOCAL_ADDR = pack_addr(XW'(X_LOC), YW'(Y_LOC));

    // Packet layout is fixed by the package; reject mismatched instances at elaboration.
    if ($clog2(X_NODES) != XW || $clog2(Y_NODES) != YW || TS_WIDTH != TS_W) begin : g_param_check
        $error("mesh_network_interface: parameters disagree with mesh_pkg packet layout");
    end

    packet_t               tx_wr_pkt;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [TX_CNT_W-1:0]   tx_level;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [RX_CNT_W-1:0]   rx_level;

    logic [STAT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [STAT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic                  dest_err_q, dest_err_d;
    logic                  overflow_q, overflow_d;

    // Handshakes: injection is gated by router enable, ejection by buffer space only.
    assign o_tx_ready = !tx_full;
    assign tx_push    = i_tx_val && !tx_full;
    assign tx_pop     = !tx_empty && i_en;
    assign o_data_val = tx_pop;
    assign o_en       = (rx_level < RX_CNT_W'(RX_DEPTH));
    assign rx_push    = i_data_val && o_en;
    assign o_rx_val   = !rx_empty;
    assign rx_pop     = !rx_empty && i_rx_ready;

    mesh_ni_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (tx_push),
        .wr_data_i (tx_wr_pkt),
        .rd_en_i   (tx_pop),
        .rd_data_o (o_data),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .count_o   (tx_level)
    );

    mesh_ni_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (rx_push),
        .wr_data_i (i_data),
        .rd_en_i   (rx_pop),
        .rd_data_o (o_rx_data),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .count_o   (rx_level)
    );

    logic unused_fifo_status;
    assign unused_fifo_status = ^{tx_level, rx_full};

    // Saturating traffic counters and sticky error flags.
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        dest_err_d = dest_err_q;
        overflow_d = overflow_q;
        if (tx_pop && tx_cnt_q != '1) tx_cnt_d = tx_cnt_q + STAT_W'(1);
        if (rx_push) begin
            if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + STAT_W'(1);
            if (i_data.dest != LOCAL_ADDR) dest_err_d = 1'b1;
        end
        if (i_data_val && !o_en) overflow_d = 1'b1;
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            dest_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            dest_err_q <= dest_err_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_tx_count = tx_cnt_q;
    assign o_rx_count = rx_cnt_q;
    assign o_dest_err = dest_err_q;
    assign o_overflow = overflow_q;

`ifdef MESH_NI_LATENCY_EN
    logic [TS_WIDTH-1:0] now_q;
    logic [TS_WIDTH-1:0] latency_q, latency_d;
    logic                latency_val_q, latency_val_d;

    // Injected packets carry this node's address and the injection time.
    always_comb begin
        tx_wr_pkt           = i_tx_data;
        tx_wr_pkt.source    = LOCAL_ADDR;
        tx_wr_pkt.timestamp = TS_W'(now_q);
    end

    // Latency is a modular difference so a counter wrap in flight still yields the right value.
    always_comb begin
        latency_d     = latency_q;
        latency_val_d = 1'b0;
        if (rx_push) begin
            latency_d     = now_q - TS_WIDTH'(i_data.timestamp);
            latency_val_d = 1'b1;
        end
    end

    // Free-running time base and latency report registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            now_q         <= '0;
            latency_q     <= '0;
            latency_val_q <= 1'b0;
        end else begin
            now_q         <= now_q + TS_WIDTH'(1);
            latency_q     <= latency_d;
            latency_val_q <= latency_val_d;
        end
    end

    assign o_latency     = latency_q;
    assign o_latency_val = latency_val_q;
`else
    // Injected packets carry this node's address; timestamp passes through untouched.
    always_comb begin
        tx_wr_pkt        = i_tx_data;
        tx_wr_pkt.source = LOCAL_ADDR;
    end

    assign o_latency     = '0;
    assign o_latency_val = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_network_interface.sv
// Randomised self-checking bench for mesh_network_interface at node (X=1, Y=2).
module tb_mesh_network_interface;
    import mesh_pkg::*;

    localparam int unsigned TXD    = 4;
    localparam addr_t       HOME   = 4'h9;   // {Y=2, X=1}
    localparam addr_t       REMOTE = 4'h3;   // {Y=0, X=3}

    logic        clk = 1'b0;
    logic        reset;
    packet_t     i_tx_data, o_data, i_data, o_rx_data;
    logic        i_tx_val, o_tx_ready, o_data_val, i_en, i_data_val, o_en, o_rx_val, i_rx_ready;
    logic [15:0] o_tx_count, o_rx_count, o_latency;
    logic        o_dest_err, o_overflow, o_latency_val;

    always #5 clk = ~clk;

    mesh_network_interface #(
        .X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(2), .TX_DEPTH(TXD), .TS_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .i_tx_data(i_tx_data), .i_tx_val(i_tx_val), .o_tx_ready(o_tx_ready),
        .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
        .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
        .o_rx_data(o_rx_data), .o_rx_val(o_rx_val), .i_rx_ready(i_rx_ready),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count),
        .o_dest_err(o_dest_err), .o_overflow(o_overflow),
        .o_latency(o_latency), .o_latency_val(o_latency_val)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    packet_t     tx_q[$];
    packet_t     rx_q[$];
    logic [15:0] m_tx_cnt, m_rx_cnt, m_lat, m_now;
    bit          m_dest_err, m_ovf, m_lat_val;
    packet_t     lb_pkt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_tx_cnt = '0; m_rx_cnt = '0; m_lat = '0; m_now = '0;
        m_dest_err = 0; m_ovf = 0; m_lat_val = 0;
    endtask

    function automatic packet_t rand_pkt(input addr_t dest);
        packet_t p;
        p.dest      = dest;
        p.source    = AW'($urandom);
        p.timestamp = TS_W'($urandom);
        p.data      = $urandom;
        return p;
    endfunction

    task automatic drive_idle();
        i_tx_val = 0; i_tx_data = '0; i_en = 0;
        i_data_val = 0; i_data = '0; i_rx_ready = 0;
    endtask

    // One clock cycle: compare mid-cycle against the model, then advance the model by the edge.
    task automatic tick();
        bit      e_rdy, e_dval, e_en, e_rval;
        packet_t p;
        @(negedge clk);
        e_rdy  = tx_q.size() < TXD;
        e_dval = (tx_q.size() != 0) && i_en;
        e_en   = rx_q.size() < 2;
        e_rval = rx_q.size() != 0;
        check_eq("tx_ready", 64'(o_tx_ready), 64'(e_rdy));
        check_eq("data_val", 64'(o_data_val), 64'(e_dval));
        if (e_dval) begin
            check_eq("tx_pkt", 64'(o_data), 64'(tx_q[0]));
            lb_pkt = o_data;
        end
        check_eq("en", 64'(o_en), 64'(e_en));
        check_eq("rx_val", 64'(o_rx_val), 64'(e_rval));
        if (e_rval) check_eq("rx_pkt", 64'(o_rx_data), 64'(rx_q[0]));
        check_eq("tx_count", 64'(o_tx_count), 64'(m_tx_cnt));
        check_eq("rx_count", 64'(o_rx_count), 64'(m_rx_cnt));
        check_eq("dest_err", 64'(o_dest_err), 64'(m_dest_err));
        check_eq("overflow", 64'(o_overflow), 64'(m_ovf));
        check_eq("latency", 64'(o_latency), 64'(m_lat));
        check_eq("latency_val", 64'(o_latency_val), 64'(m_lat_val));

        if (e_dval) begin
            void'(tx_q.pop_front());
            if (m_tx_cnt != 16'hFFFF) m_tx_cnt++;
        end
        if (i_tx_val && e_rdy) begin
            p = i_tx_data;
            p.source = HOME;
`ifdef MESH_NI_LATENCY_EN
            p.timestamp = m_now;
`endif
            tx_q.push_back(p);
        end
        if (e_rval && i_rx_ready) void'(rx_q.pop_front());
        m_lat_val = 0;
        if (i_data_val && e_en) begin
            rx_q.push_back(i_data);
            if (m_rx_cnt != 16'hFFFF) m_rx_cnt++;
            if (i_data.dest != HOME) m_dest_err = 1;
`ifdef MESH_NI_LATENCY_EN
            m_lat     = m_now - i_data.timestamp;
            m_lat_val = 1;
`endif
        end else if (i_data_val) begin
            m_ovf = 1;
        end
        m_now++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

`ifdef MESH_NI_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    initial begin
        do_reset();

        // Idle after reset
        repeat (2) tick();

        // Fill TX with router disabled, then drain in order
        for (int i = 0; i < 4; i++) begin
            i_tx_val  = 1;
            i_tx_data = rand_pkt(addr_t'($urandom_range(0, 15)));
            tick();
        end
        i_tx_val = 0;
        tick();
        check_eq("tx_full_ready", 64'(o_tx_ready), 64'(0));
        i_en = 1;
        repeat (5) tick();
        check_eq("tx_count_4", 64'(o_tx_count), 64'd4);

        // RX fill with sink stalled, third packet overflows
        i_en = 0;
        for (int i = 0; i < 3; i++) begin
            i_data_val = 1;
            i_data     = rand_pkt(HOME);
            tick();
        end
        i_data_val = 0;
        check_eq("rx_full_en", 64'(o_en), 64'(0));
        check_eq("ovf_set", 64'(o_overflow), 64'(1));
        check_eq("rx_count_2", 64'(o_rx_count), 64'd2);
        i_rx_ready = 1;
        repeat (3) tick();

        // Misaddressed packet is delivered and flags dest_err
        check_eq("dest_err_clear", 64'(o_dest_err), 64'(0));
        i_data_val = 1;
        i_data     = rand_pkt(REMOTE);
        tick();
        i_data_val = 0;
        tick();
        check_eq("dest_err_set", 64'(o_dest_err), 64'(1));
        repeat (3) tick();
        check_eq("dest_err_sticky", 64'(o_dest_err), 64'(1));

        // Latency wrap: timestamp 65530 ejected at time 4
        do_reset();
        while (m_now != 16'd4) tick();
        i_data_val = 1;
        i_data     = rand_pkt(HOME);
        i_data.timestamp = 16'd65530;
        i_rx_ready = 1;
        tick();
        i_data_val = 0;
        check_eq("lat_wrap", 64'(o_latency), LAT_EN ? 64'd10 : 64'd0);
        check_eq("lat_wrap_val", 64'(o_latency_val), 64'(LAT_EN));
        tick();

        // Loopback: inject at time 100, eject at 112
        do_reset();
        i_rx_ready = 1;
        while (m_now != 16'd100) tick();
        i_tx_val  = 1;
        i_tx_data = rand_pkt(HOME);
        tick();
        i_tx_val = 0;
        while (m_now != 16'd111) tick();
        i_en = 1;
        tick();
        i_en = 0;
        i_data_val = 1;
        i_data     = lb_pkt;
        tick();
        i_data_val = 0;
        check_eq("lat_loop", 64'(o_latency), LAT_EN ? 64'd12 : 64'd0);
        tick();

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            i_tx_val   = ($urandom_range(0, 1) == 1);
            i_tx_data  = rand_pkt(addr_t'($urandom_range(0, 15)));
            i_en       = ($urandom_range(0, 3) != 0);
            i_data_val = ($urandom_range(0, 2) != 0);
            i_data     = rand_pkt(($urandom_range(0, 7) == 0) ? addr_t'($urandom_range(0, 15)) : HOME);
            i_rx_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Async reset with both buffers full
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            i_tx_val   = 1;
            i_tx_data  = rand_pkt(HOME);
            i_data_val = (i < 3);
            i_data     = rand_pkt(HOME);
            tick();
        end
        drive_idle();
        check_eq("pre_rst_full", 64'(o_tx_ready), 64'(0));
        check_eq("pre_rst_en", 64'(o_en), 64'(0));
        #2;
        reset = 1;
        i_en  = 1;
        #1;
        check_eq("arst_tx_ready", 64'(o_tx_ready), 64'(1));
        check_eq("arst_en", 64'(o_en), 64'(1));
        check_eq("arst_data_val", 64'(o_data_val), 64'(0));
        check_eq("arst_rx_val", 64'(o_rx_val), 64'(0));
        check_eq("arst_counts", 64'({o_tx_count, o_rx_count}), 64'(0));
        check_eq("arst_flags", 64'({o_dest_err, o_overflow, o_latency_val}), 64'(0));
        check_eq("arst_latency", 64'(o_latency), 64'(0));
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        i_rx_ready = 1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
